button_conditioner: RTL and testbench

Front-end stage for the player controls that feeds the memory-mapped input registers read by the game program. It synchronizes the three raw active-low board pins (left, right, fire) into the system clock domain, debounces each one, and resolves left/right conflicts. It also converts fire presses into a rate-limited one-cycle pulse plus a sticky request that stays set until the CPU side acknowledges it. All outputs are registered and active-high; no inversion is needed downstream.

---
 rtl/button_conditioner_if.sv | 37 +++
 rtl/button_conditioner.sv | 105 ++++++++++
 tb/tb_button_conditioner.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Player-control bundle between the board pins/CPU side and the
// button conditioner: raw active-low pins in, conditioned levels out.
interface button_conditioner_if;
    logic       btn_left_n;
    logic       btn_right_n;
    logic       btn_fire_n;
    logic       fire_ack;
    logic       move_left;
    logic       move_right;
    logic       fire_pulse;
    logic       fire_req;
    logic [2:0] btn_state;

    modport master (
        output btn_left_n,
        output btn_right_n,
        output btn_fire_n,
        output fire_ack,
        input  move_left,
        input  move_right,
        input  fire_pulse,
        input  fire_req,
        input  btn_state
    );

    modport slave (
        input  btn_left_n,
        input  btn_right_n,
        input  btn_fire_n,
        input  fire_ack,
        output move_left,
        output move_right,
        output fire_pulse,
        output fire_req,
        output btn_state
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and conflict-resolves the left/right/fire pins,
// and turns fire presses into a rate-limited pulse plus a sticky request.
module button_conditioner #(
    parameter int DB_CYCLES       = 1000,
    parameter int COOLDOWN_CYCLES = 5000,
    parameter int CNT_W           = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    // Loading one less makes a rise at exactly p+COOLDOWN_CYCLES legal.
    localparam logic [CNT_W-1:0] CD_LOAD =
        (COOLDOWN_CYCLES > 0) ? CNT_W'(COOLDOWN_CYCLES - 1) : '0;

    logic [2:0]            sync1_q;
    logic [2:0]            sync2_q;
    logic [2:0]            syncd;
    logic [2:0]            s_q;
    logic [2:0]            s_d;
    logic [2:0][CNT_W-1:0] c_q;
    logic [2:0][CNT_W-1:0] c_d;
    logic                  sf_dly_q;
    logic [CNT_W-1:0]      cd_q;
    logic [CNT_W-1:0]      cd_d;
    logic                  rise;
    logic                  accept;
    logic                  req_d;

    logic                  move_left_q;
    logic                  move_right_q;
    logic                  fire_pulse_q;
    logic                  fire_req_q;
    logic [2:0]            btn_state_q;

    assign syncd = ~sync2_q;

    always_comb begin
        s_d = s_q;
        c_d = c_q;
        for (int i = 0; i < 3; i++) begin
            if (syncd[i] == s_q[i]) begin
                c_d[i] = '0;
            end else if (c_q[i] == DB_LAST) begin
                s_d[i] = syncd[i];
                c_d[i] = '0;
            end else begin
                c_d[i] = c_q[i] + 1'b1;
            end
        end
    end

    assign rise   = s_q[2] & ~sf_dly_q;
    assign accept = rise && (cd_q == '0);

    always_comb begin
        if (accept) begin
            cd_d = CD_LOAD;
        end else if (cd_q != '0) begin
            cd_d = cd_q - 1'b1;
        end else begin
            cd_d = '0;
        end
    end

    // Set beats a coincident acknowledge.
    assign req_d = accept | (fire_req_q & ~bus.fire_ack);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 3'b111;
            sync2_q      <= 3'b111;
            s_q          <= '0;
            c_q          <= '0;
            sf_dly_q     <= 1'b0;
            cd_q         <= '0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
            fire_pulse_q <= 1'b0;
            fire_req_q   <= 1'b0;
            btn_state_q  <= '0;
        end else begin
            sync1_q      <= {bus.btn_fire_n, bus.btn_right_n, bus.btn_left_n};
            sync2_q      <= sync1_q;
            s_q          <= s_d;
            c_q          <= c_d;
            sf_dly_q     <= s_q[2];
            cd_q         <= cd_d;
            move_left_q  <= s_q[0] & ~s_q[1];
            move_right_q <= s_q[1] & ~s_q[0];
            fire_pulse_q <= accept;
            fire_req_q   <= req_d;
            btn_state_q  <= s_q;
        end
    end

    assign bus.move_left  = move_left_q;
    assign bus.move_right = move_right_q;
    assign bus.fire_pulse = fire_pulse_q;
    assign bus.fire_req   = fire_req_q;
    assign bus.btn_state  = btn_state_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random pin traffic,
// checked every cycle against a delay-line/window reference model.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int CD = 10;
    localparam int W  = 20;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    button_conditioner_if bus ();

    button_conditioner #(
        .DB_CYCLES      (DB),
        .COOLDOWN_CYCLES(CD),
        .CNT_W          (W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [2:0] m_pin1, m_pin2, m_s;
    logic       m_f_old;
    logic [2:0] hist[$];
    longint     n_edge = 0;
    longint     last_acc;
    bit         have_acc;
    logic       m_ml, m_mr, m_pulse, m_req;
    logic [2:0] m_state;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h",
                     tag, n_edge, got, exp);
        end
    endtask

    // Pins reach the debouncer two edges after sampling; a level is
    // accepted once the last DB delivered samples all disagree with it.
    task automatic model_edge();
        logic acc;
        bit   all_diff;
        n_edge++;
        if (reset) begin
            m_ml = 0; m_mr = 0; m_pulse = 0; m_req = 0; m_state = '0;
            m_pin1 = 3'b111; m_pin2 = 3'b111;
            m_s = '0; m_f_old = 1'b0;
            hist.delete();
            have_acc = 0;
        end else begin
            acc = m_s[2] && !m_f_old &&
                  (!have_acc || (n_edge - last_acc) >= CD);
            m_ml    = m_s[0] && !m_s[1];
            m_mr    = m_s[1] && !m_s[0];
            m_state = m_s;
            m_pulse = acc;
            m_req   = acc ? 1'b1 : (bus.fire_ack ? 1'b0 : m_req);
            if (acc) begin
                have_acc = 1;
                last_acc = n_edge;
            end
            m_f_old = m_s[2];
            hist.push_back(~m_pin2);
            if (hist.size() > DB) hist.delete(0);
            if (hist.size() == DB) begin
                for (int i = 0; i < 3; i++) begin
                    all_diff = 1;
                    foreach (hist[j]) if (hist[j][i] == m_s[i]) all_diff = 0;
                    if (all_diff) m_s[i] = ~m_s[i];
                end
            end
            m_pin2 = m_pin1;
            m_pin1 = {bus.btn_fire_n, bus.btn_right_n, bus.btn_left_n};
        end
    endtask

    // One clock: drive inputs, let the edge happen, compare after it.
    task automatic cyc(input logic [2:0] pins_n, input logic ack,
                       input logic rst);
        bus.btn_left_n  = pins_n[0];
        bus.btn_right_n = pins_n[1];
        bus.btn_fire_n  = pins_n[2];
        bus.fire_ack    = ack;
        reset           = rst;
        @(posedge clk);
        model_edge();
        #1;
        chk("move_left",  32'(bus.move_left),  32'(m_ml));
        chk("move_right", 32'(bus.move_right), 32'(m_mr));
        chk("fire_pulse", 32'(bus.fire_pulse), 32'(m_pulse));
        chk("fire_req",   32'(bus.fire_req),   32'(m_req));
        chk("btn_state",  32'(bus.btn_state),  32'(m_state));
        if (rst)
            chk("rst_zero", 32'({bus.move_left, bus.move_right,
                bus.fire_pulse, bus.fire_req, bus.btn_state}), 32'd0);
        @(negedge clk);
    endtask

    task automatic hold(input logic [2:0] pins_n, input int n);
        for (int i = 0; i < n; i++) cyc(pins_n, 1'b0, 1'b0);
    endtask

    int pulses;

    initial begin
        bus.btn_left_n  = 1'b1;
        bus.btn_right_n = 1'b1;
        bus.btn_fire_n  = 1'b1;
        bus.fire_ack    = 1'b0;
        reset           = 1'b1;
        @(negedge clk);

        // reset with toggling pins, then idle
        for (int i = 0; i < 3; i++)
            cyc(3'($urandom_range(0, 7)), 1'b0, 1'b1);
        hold(3'b111, 10);
        chk("idle_state", 32'(bus.btn_state), 32'd0);

        // glitch filter, then a real left press
        hold(3'b110, 3);
        hold(3'b111, 10);
        chk("glitch_left", 32'(bus.move_left), 32'd0);
        hold(3'b110, 10);
        chk("held_left", 32'(bus.move_left), 32'd1);
        hold(3'b111, 10);

        // conflict
        hold(3'b110, 8);
        hold(3'b100, 10);
        chk("conflict_state", 32'(bus.btn_state), 32'd3);
        chk("conflict_move",
            32'({bus.move_left, bus.move_right}), 32'd0);
        hold(3'b101, 10);
        chk("right_only", 32'(bus.move_right), 32'd1);
        hold(3'b111, 10);

        // long fire hold: exactly one pulse
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(3'b011, 1'b0, 1'b0);
            pulses += int'(bus.fire_pulse);
        end
        chk("one_pulse", 32'(pulses), 32'd1);
        chk("req_held", 32'(bus.fire_req), 32'd1);
        cyc(3'b011, 1'b1, 1'b0);
        chk("req_acked", 32'(bus.fire_req), 32'd0);
        hold(3'b111, 20);

        // cooldown: second rise too soon, third late enough
        hold(3'b011, 4);
        hold(3'b111, 4);
        hold(3'b011, 4);
        hold(3'b111, 4);
        hold(3'b011, 6);
        hold(3'b111, 20);

        // collision: ack lands on the accepting edge
        cyc(3'b011, 1'b0, 1'b0);
        hold(3'b011, 5);
        cyc(3'b011, 1'b1, 1'b0);
        chk("collide_req", 32'(bus.fire_req), 32'd1);
        hold(3'b011, 5);

        // reset while fire held
        cyc(3'b011, 1'b0, 1'b1);
        cyc(3'b011, 1'b0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(3'b011, 1'b0, 1'b0);
            pulses += int'(bus.fire_pulse);
        end
        chk("rst_repress", 32'(pulses), 32'd1);
        hold(3'b111, 10);

        // random traffic
        for (int seg = 0; seg < 400; seg++) begin
            logic [2:0] p;
            int         len;
            p   = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 59) == 0) begin
                cyc(p, 1'b0, 1'b1);
                cyc(p, 1'b0, 1'b1);
            end
            for (int i = 0; i < len; i++)
                cyc(p, $urandom_range(0, 7) == 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
